imem_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the single-cycle core's instruction memory. It accepts a byte stream (length header, payload, checksum), packs the payload into little-endian 32-bit words and writes them sequentially into instruction memory. While loading, it holds the core in reset. It releases the core only after the checksum verifies.

---
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader into instruction memory
// Parses LEN/payload/CSUM, writes LE words, and holds the core in reset until the checksum verifies.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);
  localparam int IW = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [IW-1:0]     len_q, len_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        sum_q, sum_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       len_full;
  logic              xfer;

  assign byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);
  assign core_rst   = (state_q == RUN);
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  assign xfer     = byte_valid & byte_ready;
  assign len_full = {byte_data, len_lo_q};

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    widx_d   = widx_q;
    lane_d   = lane_q;
    sum_d    = sum_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    // start wins over any byte offered in the same cycle
    if (start) begin
      state_d = LEN0;
      widx_d  = '0;
      lane_d  = '0;
      sum_d   = '0;
    end else if (xfer) begin
      case (state_q)
        LEN0: begin
          len_lo_d = byte_data;
          state_d  = LEN1;
        end
        LEN1: begin
          len_d = IW'(len_full);
          if ({1'b0, len_full} > MAX_WORDS) state_d = ERR;
          else if (len_full == 16'd0)      state_d = CSUM;
          else                             state_d = DATA;
        end
        DATA: begin
          sum_d  = sum_q + byte_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {byte_data, word_q};
              widx_d  = widx_q + IW'(1);
              if (widx_q + IW'(1) == len_q) state_d = CSUM;
            end
          endcase
        end
        CSUM: state_d = (byte_data == sum_q) ? RUN : ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      widx_q   <= '0;
      lane_q   <= '0;
      sum_q    <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      lane_q   <= lane_d;
      sum_q    <= sum_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader
// Instance a uses ADDR_W=10; instance b uses ADDR_W=2 for capacity boundaries.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        a_ready, a_we, a_core_rst, a_done, a_error;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_ready, b_we, b_core_rst, b_done, b_error;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  int checks = 0;
  int failures = 0;

  logic [9:0]  a_wa[$];
  logic [31:0] a_wd[$];
  logic [1:0]  b_wa[$];
  logic [31:0] b_wd[$];

  imem_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .core_rst(a_core_rst), .done(a_done), .error(a_error)
  );

  imem_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .core_rst(b_core_rst), .done(b_done), .error(b_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_we === 1'b1) begin a_wa.push_back(a_addr); a_wd.push_back(a_wdata); end
    if (b_we === 1'b1) begin b_wa.push_back(b_addr); b_wd.push_back(b_wdata); end
  end

  task automatic send_byte(input bit to_b, input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (((to_b ? b_ready : a_ready) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((to_b ? b_ready : a_ready) !== 1'b1) begin
      failures++;
      $display("FAIL byte_ready_timeout got=0 exp=1 byte=%02h", b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input bit to_b, input logic [7:0] s[$], input bit gaps);
    for (int i = 0; i < s.size(); i++) begin
      send_byte(to_b, s[i]);
      if (gaps) repeat (i % 3) @(negedge clk);
    end
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_normal_result(input string tag);
    checks++;
    if (a_wa.size() !== 2) begin
      failures++; $display("FAIL %s_write_count got=%0d exp=2", tag, a_wa.size());
    end else begin
      checks++;
      if (a_wa[0] !== 10'd0 || a_wd[0] !== 32'h00500513) begin
        failures++; $display("FAIL %s_word0 got=%0h:%08h exp=0:00500513", tag, a_wa[0], a_wd[0]);
      end
      checks++;
      if (a_wa[1] !== 10'd1 || a_wd[1] !== 32'h00600593) begin
        failures++; $display("FAIL %s_word1 got=%0h:%08h exp=1:00600593", tag, a_wa[1], a_wd[1]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_ready, a_we, a_addr, a_wdata, a_core_rst, a_done, a_error} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b/%b/%h/%h/%b/%b/%b exp=all zero",
                           a_ready, a_we, a_addr, a_wdata, a_core_rst, a_done, a_error);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || a_core_rst !== 1'b0) begin
      failures++; $display("FAIL reset_idle got=ready%b core_rst%b exp=0/0", a_ready, a_core_rst);
    end
  endtask

  task automatic test_normal();
    logic [7:0] hdr[$] = '{8'h02, 8'h00};
    logic [7:0] pay[$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00, 8'h60};
    a_wa.delete(); a_wd.delete();
    pulse_start(0);
    send_stream(0, hdr, 0);
    checks++;
    if (a_core_rst !== 1'b0 || a_ready !== 1'b1) begin
      failures++; $display("FAIL normal_loading got=core_rst%b ready%b exp=0/1", a_core_rst, a_ready);
    end
    send_stream(0, pay, 0);
    check_normal_result("normal");
    checks++;
    if (a_done !== 1'b1 || a_core_rst !== 1'b1 || a_error !== 1'b0 || a_ready !== 1'b0) begin
      failures++; $display("FAIL normal_run got=done%b core_rst%b err%b ready%b exp=1/1/0/0",
                           a_done, a_core_rst, a_error, a_ready);
    end
  endtask

  task automatic test_restart();
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    a_wa.delete(); a_wd.delete();
    pulse_start(0);
    checks++;
    if (a_core_rst !== 1'b0 || a_done !== 1'b0 || a_ready !== 1'b1) begin
      failures++; $display("FAIL restart_drop got=core_rst%b done%b ready%b exp=0/0/1",
                           a_core_rst, a_done, a_ready);
    end
    send_stream(0, s, 0);
    checks++;
    if (a_wa.size() !== 1 || a_wa[0] !== 10'd0 || a_wd[0] !== 32'hDEADBEEF || a_done !== 1'b1) begin
      failures++; $display("FAIL restart_overwrite got=n%0d data%08h done%b exp=n1 deadbeef done1",
                           a_wa.size(), (a_wd.size() > 0) ? a_wd[0] : 32'h0, a_done);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] s[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00, 8'h52};
    a_wa.delete(); a_wd.delete();
    pulse_start(0);
    send_stream(0, s, 0);
    check_normal_result("badcsum");
    checks++;
    if (a_error !== 1'b1 || a_core_rst !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL badcsum_err got=err%b core_rst%b done%b exp=1/0/0",
                           a_error, a_core_rst, a_done);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] s[$] = '{8'h00, 8'h00, 8'h00};
    a_wa.delete(); a_wd.delete();
    pulse_start(0);
    checks++;
    if (a_error !== 1'b0) begin
      failures++; $display("FAIL zero_err_cleared got=%b exp=0", a_error);
    end
    send_stream(0, s, 0);
    checks++;
    if (a_wa.size() !== 0 || a_done !== 1'b1) begin
      failures++; $display("FAIL zero_len got=writes%0d done%b exp=0/1", a_wa.size(), a_done);
    end
  endtask

  task automatic test_start_priority();
    logic [7:0] s[$] = '{8'h00, 8'h00, 8'h00};
    pulse_start(0);
    byte_valid = 1'b1;
    byte_data  = 8'h09;
    start_a    = 1'b1;
    @(negedge clk);
    start_a    = 1'b0;
    byte_valid = 1'b0;
    send_stream(0, s, 0);
    checks++;
    if (a_done !== 1'b1) begin
      failures++; $display("FAIL start_priority got=done%b exp=1", a_done);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] s[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00, 8'h60};
    a_wa.delete(); a_wd.delete();
    pulse_start(0);
    send_stream(0, s, 1);
    check_normal_result("gaps");
    checks++;
    if (a_done !== 1'b1 || a_core_rst !== 1'b1 || a_error !== 1'b0) begin
      failures++; $display("FAIL gaps_run got=done%b core_rst%b err%b exp=1/1/0",
                           a_done, a_core_rst, a_error);
    end
  endtask

  task automatic test_oversize();
    logic [7:0] s[$] = '{8'h05, 8'h00};
    logic [7:0] full[$];
    logic [7:0] sum = 8'h00;
    logic [7:0] bv;
    b_wa.delete(); b_wd.delete();
    pulse_start(1);
    send_stream(1, s, 0);
    checks++;
    if (b_error !== 1'b1 || b_ready !== 1'b0 || b_wa.size() !== 0 || b_core_rst !== 1'b0) begin
      failures++; $display("FAIL oversize got=err%b ready%b writes%0d core_rst%b exp=1/0/0/0",
                           b_error, b_ready, b_wa.size(), b_core_rst);
    end
    full = '{8'h04, 8'h00};
    for (int k = 0; k < 16; k++) begin
      bv = 8'(k * 7 + 3);
      full.push_back(bv);
      sum += bv;
    end
    full.push_back(sum);
    pulse_start(1);
    send_stream(1, full, 0);
    checks++;
    if (b_wa.size() !== 4) begin
      failures++; $display("FAIL capacity_count got=%0d exp=4", b_wa.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (b_wa[w] !== 2'(w) ||
            b_wd[w] !== {full[2+4*w+3], full[2+4*w+2], full[2+4*w+1], full[2+4*w]}) begin
          failures++; $display("FAIL capacity_word%0d got=%0h:%08h exp=%0h:%08h", w, b_wa[w], b_wd[w],
                               w, {full[2+4*w+3], full[2+4*w+2], full[2+4*w+1], full[2+4*w]});
        end
      end
    end
    checks++;
    if (b_done !== 1'b1 || b_error !== 1'b0) begin
      failures++; $display("FAIL capacity_done got=done%b err%b exp=1/0", b_done, b_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93};
    pulse_start(0);
    send_stream(0, s, 0);
    rst = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_we, a_addr, a_wdata, a_core_rst, a_done, a_error} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%b/%b/%h/%h/%b/%b/%b exp=all zero",
                           a_ready, a_we, a_addr, a_wdata, a_core_rst, a_done, a_error);
    end
    a_wa.delete(); a_wd.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h02;
    repeat (4) @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || a_core_rst !== 1'b0 || a_wa.size() !== 0) begin
      failures++; $display("FAIL midreset_idle got=ready%b core_rst%b writes%0d exp=0/0/0",
                           a_ready, a_core_rst, a_wa.size());
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_restart();
    test_bad_csum();
    test_zero_len();
    test_start_priority();
    test_gaps();
    test_oversize();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
